mem_stage: RTL and testbench

- Registered memory-access stage directly downstream of the execute stage.
- Latches the execute stage's result bundle (ALUop, write-back register number/enable, ALU result, memory address, store data).
- Performs lw/sw against the data memory over a req/ack handshake and presents a registered write-back bundle to the register-file write stage.
- Stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bundle, runs lw/sw over a
// req/ack handshake with a timeout, and presents a registered write-back bundle.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [4:0]  ALUop_i,
   input  logic        WriteReg_i,
   input  logic [4:0]  WriteDataNum_i,
   input  logic [31:0] WriteData_i,
   input  logic [31:0] MemAddr_i,
   input  logic [31:0] StoreData_i,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        wb_valid_o,
   output logic        WriteReg_o,
   output logic [4:0]  WriteDataNum_o,
   output logic [31:0] WriteData_o,
   output logic        err_o
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [4:0] OP_LW = 5'b10100;
   localparam logic [4:0] OP_SW = 5'b10101;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   sdata_q, sdata_d;
   logic          wb_valid_q, wb_valid_d;
   logic          err_q, err_d;
   logic          wreg_q, wreg_d;
   logic [4:0]    wnum_q, wnum_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          lat_lw_q, lat_lw_d;
   logic          lat_wreg_q, lat_wreg_d;
   logic [4:0]    lat_num_q, lat_num_d;

   logic is_lw, is_sw, is_mem, misaligned;

   assign is_lw      = (ALUop_i == OP_LW);
   assign is_sw      = (ALUop_i == OP_SW);
   assign is_mem     = is_lw | is_sw;
   assign misaligned = (MemAddr_i[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      wb_valid_d = 1'b0;
      err_d      = 1'b0;
      wreg_d     = wreg_q;
      wnum_d     = wnum_q;
      wdata_d    = wdata_q;
      lat_lw_d   = lat_lw_q;
      lat_wreg_d = lat_wreg_q;
      lat_num_d  = lat_num_q;

      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wreg_d     = WriteReg_i;
                  wnum_d     = WriteDataNum_i;
                  wdata_d    = WriteData_i;
               end else if (misaligned) begin
                  err_d      = 1'b1;
                  wb_valid_d = 1'b1;
                  wreg_d     = 1'b0;
                  wnum_d     = WriteDataNum_i;
                  wdata_d    = 32'd0;
               end else begin
                  state_d    = S_BUSY;
                  cnt_d      = '0;
                  req_d      = 1'b1;
                  we_d       = is_sw;
                  addr_d     = {MemAddr_i[31:2], 2'b00};
                  sdata_d    = StoreData_i;
                  lat_lw_d   = is_lw;
                  lat_wreg_d = WriteReg_i & is_lw;
                  lat_num_d  = WriteDataNum_i;
               end
            end
         end

         S_BUSY: begin
            // An ack on the final timeout edge still completes normally.
            if (mem_ack_i) begin
               state_d    = S_IDLE;
               req_d      = 1'b0;
               wb_valid_d = 1'b1;
               wnum_d     = lat_num_q;
               wreg_d     = lat_wreg_q;
               wdata_d    = lat_lw_q ? mem_rdata_i : 32'd0;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = S_IDLE;
               req_d      = 1'b0;
               err_d      = 1'b1;
               wb_valid_d = 1'b1;
               wnum_d     = lat_num_q;
               wreg_d     = 1'b0;
               wdata_d    = 32'd0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         sdata_q    <= 32'd0;
         wb_valid_q <= 1'b0;
         err_q      <= 1'b0;
         wreg_q     <= 1'b0;
         wnum_q     <= 5'd0;
         wdata_q    <= 32'd0;
         lat_lw_q   <= 1'b0;
         lat_wreg_q <= 1'b0;
         lat_num_q  <= 5'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         wb_valid_q <= wb_valid_d;
         err_q      <= err_d;
         wreg_q     <= wreg_d;
         wnum_q     <= wnum_d;
         wdata_q    <= wdata_d;
         lat_lw_q   <= lat_lw_d;
         lat_wreg_q <= lat_wreg_d;
         lat_num_q  <= lat_num_d;
      end
   end

   assign stall_o        = (state_q == S_BUSY);
   assign mem_req_o      = req_q;
   assign mem_we_o       = we_q;
   assign mem_addr_o     = addr_q;
   assign mem_wdata_o    = sdata_q;
   assign wb_valid_o     = wb_valid_q;
   assign err_o          = err_q;
   assign WriteReg_o     = wreg_q;
   assign WriteDataNum_o = wnum_q;
   assign WriteData_o    = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed transactions, a transaction-level reference
// model compared every cycle, and hand-computed literal checks per scenario.
module tb_mem_stage;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [4:0]  ALUop_i;
   logic        WriteReg_i;
   logic [4:0]  WriteDataNum_i;
   logic [31:0] WriteData_i;
   logic [31:0] MemAddr_i;
   logic [31:0] StoreData_i;
   logic        stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        wb_valid_o;
   logic        WriteReg_o;
   logic [4:0]  WriteDataNum_o;
   logic [31:0] WriteData_o;
   logic        err_o;

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;

   mem_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .ALUop_i        (ALUop_i),
      .WriteReg_i     (WriteReg_i),
      .WriteDataNum_i (WriteDataNum_i),
      .WriteData_i    (WriteData_i),
      .MemAddr_i      (MemAddr_i),
      .StoreData_i    (StoreData_i),
      .stall_o        (stall_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_ack_i      (mem_ack_i),
      .mem_rdata_i    (mem_rdata_i),
      .wb_valid_o     (wb_valid_o),
      .WriteReg_o     (WriteReg_o),
      .WriteDataNum_o (WriteDataNum_o),
      .WriteData_o    (WriteData_o),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one pending access at most, aborted after TIMEOUT edges
   // without an ack.
   logic        m_busy = 1'b0;
   int          m_wait = 0;
   logic        p_lw = 1'b0, p_wreg = 1'b0;
   logic [4:0]  p_num = 5'd0;
   logic        e_req = 1'b0, e_we = 1'b0, e_wbv = 1'b0, e_err = 1'b0, e_wreg = 1'b0;
   logic [31:0] e_addr = 32'd0, e_sdata = 32'd0, e_data = 32'd0;
   logic [4:0]  e_num = 5'd0;

   always @(posedge clk) begin
      e_wbv = 1'b0;
      e_err = 1'b0;
      if (rst) begin
         m_busy = 1'b0; m_wait = 0;
         e_req = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_sdata = 32'd0;
         e_wreg = 1'b0; e_num = 5'd0; e_data = 32'd0;
      end else if (!m_busy) begin
         if (valid_i) begin
            if (ALUop_i != 5'b10100 && ALUop_i != 5'b10101) begin
               e_wbv = 1'b1; e_wreg = WriteReg_i; e_num = WriteDataNum_i; e_data = WriteData_i;
            end else if (MemAddr_i % 4 != 0) begin
               e_err = 1'b1; e_wbv = 1'b1; e_wreg = 1'b0; e_num = WriteDataNum_i; e_data = 32'd0;
            end else begin
               m_busy = 1'b1; m_wait = 0;
               e_req = 1'b1; e_we = (ALUop_i == 5'b10101);
               e_addr = MemAddr_i; e_sdata = StoreData_i;
               p_lw = (ALUop_i == 5'b10100);
               p_wreg = p_lw ? WriteReg_i : 1'b0;
               p_num = WriteDataNum_i;
            end
         end
      end else if (mem_ack_i) begin
         m_busy = 1'b0; e_req = 1'b0; e_wbv = 1'b1;
         e_num = p_num; e_wreg = p_wreg;
         e_data = p_lw ? mem_rdata_i : 32'd0;
      end else begin
         m_wait++;
         if (m_wait == TIMEOUT) begin
            m_busy = 1'b0; e_req = 1'b0; e_wbv = 1'b1; e_err = 1'b1;
            e_num = p_num; e_wreg = 1'b0; e_data = 32'd0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", 32'(stall_o), 32'(m_busy));
         chk("req", 32'(mem_req_o), 32'(e_req));
         chk("wb_valid", 32'(wb_valid_o), 32'(e_wbv));
         chk("err", 32'(err_o), 32'(e_err));
         chk("wreg", 32'(WriteReg_o), 32'(e_wreg));
         chk("wnum", 32'(WriteDataNum_o), 32'(e_num));
         chk("wdata", WriteData_o, e_data);
         if (e_req) begin
            chk("we", 32'(mem_we_o), 32'(e_we));
            chk("addr", mem_addr_o, e_addr);
            chk("sdata", mem_wdata_o, e_sdata);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic wr, input logic [4:0] num,
                        input logic [31:0] wd, input logic [31:0] ad, input logic [31:0] sd);
      valid_i = v; ALUop_i = op; WriteReg_i = wr; WriteDataNum_i = num;
      WriteData_i = wd; MemAddr_i = ad; StoreData_i = sd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
      tick(); chk_en = 1'b1; tick();
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_wdata", WriteData_o, 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      $display("[TB] reset done");
      rst = 1'b0;

      // add -> one-cycle write-back
      drive(1'b1, 5'b01101, 1'b1, 5'd3, 32'h5, 32'h0, 32'h0);
      tick(); valid_i = 1'b0;
      chk("add_wbv", 32'(wb_valid_o), 32'd1);
      chk("add_data", WriteData_o, 32'h5);
      chk("add_num", 32'(WriteDataNum_o), 32'd3);
      chk("add_req", 32'(mem_req_o), 32'd0);
      $display("[TB] add r3=5 -> data %h", WriteData_o);

      // back-to-back ALU ops
      drive(1'b1, 5'b00001, 1'b1, 5'd4, 32'hA, 32'h0, 32'h0);
      tick(); chk("b2b_1", WriteData_o, 32'hA);
      drive(1'b1, 5'b00010, 1'b0, 5'd5, 32'hB, 32'h0, 32'h0);
      tick(); valid_i = 1'b0;
      chk("b2b_2", WriteData_o, 32'hB);
      chk("b2b_wbv", 32'(wb_valid_o), 32'd1);
      tick(); chk("b2b_idle_wbv", 32'(wb_valid_o), 32'd0);
      $display("[TB] back-to-back ALU ops done");

      // lw with ack three cycles after request
      drive(1'b1, 5'b10100, 1'b1, 5'd7, 32'h0, 32'h100, 32'h0);
      tick(); valid_i = 1'b0;
      n = 0;
      for (int k = 0; k < 3; k++) begin
         if (mem_req_o && stall_o && mem_addr_o == 32'h100 && !mem_we_o) n++;
         if (k == 2) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; end
         tick();
      end
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      chk("lw_req_cycles", 32'(n), 32'd3);
      chk("lw_wbv", 32'(wb_valid_o), 32'd1);
      chk("lw_data", WriteData_o, 32'hDEADBEEF);
      chk("lw_wreg", 32'(WriteReg_o), 32'd1);
      chk("lw_num", 32'(WriteDataNum_o), 32'd7);
      chk("lw_req_drop", 32'(mem_req_o), 32'd0);
      $display("[TB] lw 0x100 -> data %h", WriteData_o);

      // sw acked immediately; next bundle waits out the busy cycle
      drive(1'b1, 5'b10101, 1'b1, 5'd6, 32'h0, 32'h204, 32'h1234);
      tick();
      chk("sw_we", 32'(mem_we_o), 32'd1);
      chk("sw_wdata", mem_wdata_o, 32'h1234);
      drive(1'b1, 5'b01101, 1'b1, 5'd9, 32'h77, 32'h0, 32'h0);
      mem_ack_i = 1'b1;
      tick(); mem_ack_i = 1'b0;
      chk("sw_wbv", 32'(wb_valid_o), 32'd1);
      chk("sw_wreg", 32'(WriteReg_o), 32'd0);
      tick(); valid_i = 1'b0;
      chk("after_sw_data", WriteData_o, 32'h77);
      $display("[TB] sw 0x204 then add r9=%h", WriteData_o);

      // misaligned lw
      drive(1'b1, 5'b10100, 1'b1, 5'd2, 32'h0, 32'h102, 32'h0);
      tick(); valid_i = 1'b0;
      chk("mis_err", 32'(err_o), 32'd1);
      chk("mis_wreg", 32'(WriteReg_o), 32'd0);
      chk("mis_req", 32'(mem_req_o), 32'd0);
      tick(); chk("mis_err_pulse", 32'(err_o), 32'd0);
      $display("[TB] misaligned lw 0x102 -> err");

      // timeout
      drive(1'b1, 5'b10100, 1'b1, 5'd11, 32'h0, 32'h200, 32'h0);
      tick(); valid_i = 1'b0;
      n = 0;
      while (mem_req_o && n < 40) begin n++; tick(); end
      chk("to_req_cycles", 32'(n), 32'd16);
      chk("to_err", 32'(err_o), 32'd1);
      chk("to_wreg", 32'(WriteReg_o), 32'd0);
      mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
      tick(); mem_ack_i = 1'b0;
      chk("late_ack_wbv", 32'(wb_valid_o), 32'd0);
      chk("late_ack_data", WriteData_o, 32'd0);
      $display("[TB] lw timeout after %0d cycles", n);

      // reset during BUSY
      drive(1'b1, 5'b10100, 1'b1, 5'd8, 32'h0, 32'h300, 32'h0);
      tick(); valid_i = 1'b0;
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      chk("rst_busy_req", 32'(mem_req_o), 32'd0);
      chk("rst_busy_addr", mem_addr_o, 32'd0);
      chk("rst_busy_wbv", 32'(wb_valid_o), 32'd0);
      mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
      tick(); mem_ack_i = 1'b0;
      chk("rst_late_ack", 32'(wb_valid_o), 32'd0);
      drive(1'b1, 5'b01101, 1'b1, 5'd10, 32'h42, 32'h0, 32'h0);
      tick(); valid_i = 1'b0;
      chk("post_rst_add", WriteData_o, 32'h42);
      tick();
      $display("[TB] reset in BUSY then add r10=%h", WriteData_o);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
